// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants and types.
// Geometry defaults and the per-cycle arbitration decision.
package vga_pkg;

    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int DEF_FB_AW = 15;
    localparam int DEF_FB_DW = 3;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } arb_op_e;

    // Linear word address of pixel (x, y) in the row-major framebuffer.
    function automatic logic [DEF_FB_AW-1:0] pix_addr(input int x, input int y);
        return DEF_FB_AW'(y * FB_W + x);
    endfunction

endpackage

// File: rtl/vga_wr_fifo.sv
// Small synchronous FIFO holding pending framebuffer writes (address + pixel).
// The head entry is visible combinationally so the arbiter can pop and issue in one step.
module vga_wr_fifo
    import vga_pkg::*;
#(
    parameter int AW    = DEF_FB_AW,
    parameter int DW    = DEF_FB_DW,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_25,
    input  logic          rst_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [AW+DW-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_25) begin
        if (do_push) begin
            mem[wr_ptr] <= {push_addr, push_data};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    assign {head_addr, head_data} = mem[rd_ptr];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads always win, buffered writes
// drain in idle cycles. Reads return with a fixed three-cycle latency.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int FB_AW    = DEF_FB_AW,
    parameter int FB_DW    = DEF_FB_DW,
    parameter int WF_DEPTH = 4
) (
    input  logic             clk_25,
    input  logic             rst_n,
    input  logic             disp_req,
    input  logic [FB_AW-1:0] disp_addr,
    output logic [FB_DW-1:0] disp_data,
    output logic             disp_valid,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [FB_AW-1:0] wr_addr,
    input  logic [FB_DW-1:0] wr_data,
    output logic             ram_en,
    output logic             ram_we,
    output logic [FB_AW-1:0] ram_addr,
    output logic [FB_DW-1:0] ram_wdata,
    input  logic [FB_DW-1:0] ram_rdata,
    output logic [2:0]       wf_level,
    output logic [15:0]      wr_stall_cnt
);

    localparam int LW = $clog2(WF_DEPTH + 1);

    logic [FB_AW-1:0] head_addr;
    logic [FB_DW-1:0] head_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LW-1:0]    level;
    logic [LW-1:0]    level_next;
    logic             push;
    logic             pop;
    logic             rd_stage2;
    arb_op_e          op;

    assign push = wr_valid && wr_ready && !fifo_full;
    assign pop  = (op == OP_WRITE);

    vga_wr_fifo #(
        .AW    (FB_AW),
        .DW    (FB_DW),
        .DEPTH (WF_DEPTH)
    ) u_wr_fifo (
        .clk_25    (clk_25),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // Scan-out has absolute priority; writes only use cycles the display leaves free.
    always_comb begin
        op = OP_IDLE;
        if (disp_req) begin
            op = OP_READ;
        end else if (!fifo_empty) begin
            op = OP_WRITE;
        end
    end

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en <= (op != OP_IDLE);
            ram_we <= (op == OP_WRITE);
            case (op)
                OP_READ: begin
                    ram_addr <= disp_addr;
                end
                OP_WRITE: begin
                    ram_addr  <= head_addr;
                    ram_wdata <= head_data;
                end
                default: begin
                end
            endcase
        end
    end

    // A read command on the RAM port returns data next cycle, captured one cycle later.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            rd_stage2  <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            rd_stage2  <= ram_en && !ram_we;
            disp_valid <= rd_stage2;
            if (rd_stage2) begin
                disp_data <= ram_rdata;
            end
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ready     <= 1'b0;
            wr_stall_cnt <= '0;
        end else begin
            wr_ready <= (level_next < LW'(WF_DEPTH));
            if (wr_valid && !wr_ready && (wr_stall_cnt != 16'hFFFF)) begin
                wr_stall_cnt <= wr_stall_cnt + 16'd1;
            end
        end
    end

    assign wf_level = 3'(level);

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural single-port RAM.
// Table vectors cover the single-cycle behaviour; sequences cover stall, drain and reset.
module tb_vga_fb_arbiter;

    logic        clk_25 = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp_req = 1'b0;
    logic [14:0] disp_addr = '0;
    logic [2:0]  disp_data;
    logic        disp_valid;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [14:0] wr_addr = '0;
    logic [2:0]  wr_data = '0;
    logic        ram_en;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [2:0]  ram_wdata;
    logic [2:0]  ram_rdata = '0;
    logic [2:0]  wf_level;
    logic [15:0] wr_stall_cnt;

    logic [2:0]  ram_mem [0:32767];
    int          ram_writes = 0;

    int check_count = 0;
    int pass_count = 0;

    typedef struct {
        logic        dr;
        logic [14:0] da;
        logic        wv;
        logic [14:0] wa;
        logic [2:0]  wd;
        logic        en;
        logic        we;
        logic [14:0] addr;
        logic [2:0]  wdata;
        logic        dv;
        logic [2:0]  dd;
        int          lvl;
        logic        rdy;
    } vec_t;

    vec_t vecs [16];

    vga_fb_arbiter dut (
        .clk_25       (clk_25),
        .rst_n        (rst_n),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_data    (disp_data),
        .disp_valid   (disp_valid),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .wf_level     (wf_level),
        .wr_stall_cnt (wr_stall_cnt)
    );

    always #5 clk_25 = ~clk_25;

    always @(posedge clk_25) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr] <= ram_wdata;
                ram_writes <= ram_writes + 1;
            end else begin
                ram_rdata <= ram_mem[ram_addr];
            end
        end
    end

    function automatic vec_t mk(input logic dr, input logic [14:0] da, input logic wv,
                                input logic [14:0] wa, input logic [2:0] wd,
                                input logic en, input logic we, input logic [14:0] addr,
                                input logic [2:0] wdata, input logic dv, input logic [2:0] dd,
                                input int lvl, input logic rdy);
        vec_t v;
        v.dr = dr; v.da = da; v.wv = wv; v.wa = wa; v.wd = wd;
        v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
        v.dv = dv; v.dd = dd; v.lvl = lvl; v.rdy = rdy;
        return v;
    endfunction

    task automatic step();
        @(posedge clk_25);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        disp_req  = v.dr;
        disp_addr = v.da;
        wr_valid  = v.wv;
        wr_addr   = v.wa;
        wr_data   = v.wd;
        step();
    endtask

    initial begin
        int accepted;
        int wr_idx;
        int writes_before;
        int dv_seen;
        int en_seen;
        logic hs;

        for (int a = 0; a < 32768; a++) begin
            ram_mem[a] <= 3'b000;
        end
        ram_mem[15'h005] <= 3'b010;
        ram_mem[15'h006] <= 3'b111;
        ram_mem[15'h010] <= 3'b110;

        //          dr da       wv wa       wd    en we addr     wdata dv dd  lvl rdy
        vecs[0]  = mk(0, 15'h000, 1, 15'h123, 3'd5, 0, 0, 15'h000, 3'd0, 0, 3'd0, 1, 1);
        vecs[1]  = mk(0, 15'h000, 0, 15'h000, 3'd0, 1, 1, 15'h123, 3'd5, 0, 3'd0, 0, 1);
        vecs[2]  = mk(0, 15'h000, 0, 15'h000, 3'd0, 0, 0, 15'h123, 3'd5, 0, 3'd0, 0, 1);
        vecs[3]  = mk(1, 15'h005, 0, 15'h000, 3'd0, 1, 0, 15'h005, 3'd5, 0, 3'd0, 0, 1);
        vecs[4]  = mk(1, 15'h006, 0, 15'h000, 3'd0, 1, 0, 15'h006, 3'd5, 0, 3'd0, 0, 1);
        vecs[5]  = mk(0, 15'h000, 0, 15'h000, 3'd0, 0, 0, 15'h006, 3'd5, 1, 3'd2, 0, 1);
        vecs[6]  = mk(0, 15'h000, 0, 15'h000, 3'd0, 0, 0, 15'h006, 3'd5, 1, 3'd7, 0, 1);
        vecs[7]  = mk(1, 15'h010, 1, 15'h010, 3'd1, 1, 0, 15'h010, 3'd5, 0, 3'd7, 1, 1);
        vecs[8]  = mk(0, 15'h000, 0, 15'h000, 3'd0, 1, 1, 15'h010, 3'd1, 0, 3'd7, 0, 1);
        vecs[9]  = mk(1, 15'h010, 0, 15'h000, 3'd0, 1, 0, 15'h010, 3'd1, 1, 3'd6, 0, 1);
        vecs[10] = mk(0, 15'h000, 0, 15'h000, 3'd0, 0, 0, 15'h010, 3'd1, 0, 3'd6, 0, 1);
        vecs[11] = mk(0, 15'h000, 0, 15'h000, 3'd0, 0, 0, 15'h010, 3'd1, 1, 3'd1, 0, 1);
        vecs[12] = mk(0, 15'h000, 1, 15'h020, 3'd3, 0, 0, 15'h010, 3'd1, 0, 3'd1, 1, 1);
        vecs[13] = mk(0, 15'h000, 1, 15'h021, 3'd4, 1, 1, 15'h020, 3'd3, 0, 3'd1, 1, 1);
        vecs[14] = mk(0, 15'h000, 0, 15'h000, 3'd0, 1, 1, 15'h021, 3'd4, 0, 3'd1, 0, 1);
        vecs[15] = mk(0, 15'h000, 0, 15'h000, 3'd0, 0, 0, 15'h021, 3'd4, 0, 3'd1, 0, 1);

        $display("[TB] reset phase");
        step();
        step();
        checkOutput("rst.wr_ready", wr_ready, 0);
        checkOutput("rst.ram_en", ram_en, 0);
        checkOutput("rst.wf_level", wf_level, 0);
        checkOutput("rst.disp_valid", disp_valid, 0);
        checkOutput("rst.stall_cnt", wr_stall_cnt, 0);

        rst_n = 1'b1;
        step();
        checkOutput("rel.wr_ready", wr_ready, 1);
        checkOutput("rel.ram_en", ram_en, 0);
        checkOutput("rel.ram_we", ram_we, 0);
        checkOutput("rel.ram_addr", ram_addr, 0);
        checkOutput("rel.ram_wdata", ram_wdata, 0);
        checkOutput("rel.wf_level", wf_level, 0);

        $display("[TB] vector table");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d.ram_en", i), ram_en, vecs[i].en);
            checkOutput($sformatf("v%0d.ram_we", i), ram_we, vecs[i].we);
            checkOutput($sformatf("v%0d.ram_addr", i), ram_addr, vecs[i].addr);
            checkOutput($sformatf("v%0d.ram_wdata", i), ram_wdata, vecs[i].wdata);
            checkOutput($sformatf("v%0d.disp_valid", i), disp_valid, vecs[i].dv);
            checkOutput($sformatf("v%0d.disp_data", i), disp_data, vecs[i].dd);
            checkOutput($sformatf("v%0d.wf_level", i), wf_level, vecs[i].lvl);
            checkOutput($sformatf("v%0d.wr_ready", i), wr_ready, vecs[i].rdy);
        end
        checkOutput("tbl.stall_cnt", wr_stall_cnt, 0);

        $display("[TB] write starvation under continuous scan-out");
        accepted = 0;
        wr_idx = 0;
        writes_before = ram_writes;
        for (int c = 0; c < 20; c++) begin
            disp_req  = 1'b1;
            disp_addr = 15'(15'h300 + c);
            wr_valid  = (wr_idx < 6);
            wr_addr   = 15'(15'h200 + wr_idx);
            wr_data   = 3'(wr_idx + 1);
            hs = wr_valid && wr_ready;
            step();
            if (hs) begin
                accepted++;
                wr_idx++;
            end
        end
        checkOutput("stall.accepted", accepted, 4);
        checkOutput("stall.wf_level", wf_level, 4);
        checkOutput("stall.wr_ready", wr_ready, 0);
        checkOutput("stall.stall_cnt", wr_stall_cnt, 16);
        checkOutput("stall.ram_writes", ram_writes - writes_before, 0);

        disp_req = 1'b0;
        wr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput($sformatf("drain%0d.ram_en", k), ram_en, 1);
            checkOutput($sformatf("drain%0d.ram_we", k), ram_we, 1);
            checkOutput($sformatf("drain%0d.ram_addr", k), ram_addr, 32'h200 + k);
            checkOutput($sformatf("drain%0d.ram_wdata", k), ram_wdata, k + 1);
            checkOutput($sformatf("drain%0d.wf_level", k), wf_level, 3 - k);
        end
        checkOutput("drain.wr_ready", wr_ready, 1);
        step();
        checkOutput("drain.idle_en", ram_en, 0);

        $display("[TB] reset with writes queued and reads in flight");
        disp_req = 1'b0;
        wr_valid = 1'b1;
        wr_addr = 15'h040;
        wr_data = 3'b011;
        step();
        disp_req = 1'b1;
        disp_addr = 15'h050;
        wr_addr = 15'h041;
        wr_data = 3'b100;
        step();
        disp_addr = 15'h051;
        wr_addr = 15'h042;
        wr_data = 3'b110;
        step();
        checkOutput("mid.wf_level", wf_level, 3);
        disp_req = 1'b0;
        wr_valid = 1'b0;
        writes_before = ram_writes;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst.wf_level", wf_level, 0);
        checkOutput("mid_rst.wr_ready", wr_ready, 0);
        checkOutput("mid_rst.ram_en", ram_en, 0);
        checkOutput("mid_rst.ram_addr", ram_addr, 0);
        checkOutput("mid_rst.disp_valid", disp_valid, 0);
        checkOutput("mid_rst.stall_cnt", wr_stall_cnt, 0);
        step();
        rst_n = 1'b1;
        dv_seen = 0;
        en_seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 0) begin
                checkOutput("post_rst.wr_ready", wr_ready, 1);
            end
            if (disp_valid) dv_seen++;
            if (ram_en) en_seen++;
        end
        checkOutput("post_rst.disp_valid_pulses", dv_seen, 0);
        checkOutput("post_rst.ram_cmds", en_seen, 0);
        checkOutput("post_rst.ram_writes", ram_writes - writes_before, 0);
        checkOutput("post_rst.wf_level", wf_level, 0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
